cdb_arbiter: RTL

- Sits directly downstream of the reservation stations and their functional units.
- Each cycle it picks at most one station whose result is ready, using round-robin priority.
- For the winner it drives the registered common-data-bus broadcast, the retire strobe back to that station, and the architectural register-file write.
- Every reservation station and the register alias logic consume its broadcast.

---
 rtl/cdb_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: round-robin pick of one ready reservation station per cycle,
// registered broadcast, retire strobe and register-file write for the winner.
module cdb_arbiter #(
    parameter int unsigned NUM_RS         = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned RS_ID_WIDTH    = (NUM_RS > 1) ? $clog2(NUM_RS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_RS-1:0]                ready_i,
    input  logic [NUM_RS*DATA_WIDTH-1:0]     result_i,
    input  logic [NUM_RS*REG_ADDR_WIDTH-1:0] rd_i,
    input  logic [NUM_RS-1:0]                writes_rd_i,
    output logic [NUM_RS-1:0]                retire_o,
    output logic                             bcast_en_o,
    output logic [DATA_WIDTH-1:0]            bcast_data_o,
    output logic [RS_ID_WIDTH-1:0]           bcast_rs_o,
    output logic                             rf_we_o,
    output logic [REG_ADDR_WIDTH-1:0]        rf_waddr_o,
    output logic [DATA_WIDTH-1:0]            rf_wdata_o
);

    localparam int unsigned LAST_RESET = NUM_RS - 1;

    logic [NUM_RS-1:0]         retire_q,     retire_d;
    logic                      bcast_en_q,   bcast_en_d;
    logic [DATA_WIDTH-1:0]     bcast_data_q, bcast_data_d;
    logic [RS_ID_WIDTH-1:0]    bcast_rs_q,   bcast_rs_d;
    logic                      rf_we_q,      rf_we_d;
    logic [REG_ADDR_WIDTH-1:0] rf_waddr_q,   rf_waddr_d;
    logic [DATA_WIDTH-1:0]     rf_wdata_q,   rf_wdata_d;
    logic [RS_ID_WIDTH-1:0]    last_q,       last_d;
    logic [NUM_RS-1:0]         inflight_q,   inflight_d;

    logic [DATA_WIDTH-1:0]     res_a [NUM_RS];
    logic [REG_ADDR_WIDTH-1:0] rd_a  [NUM_RS];
    logic [NUM_RS-1:0]         eligible_c;
    logic                      grant_c;
    logic [RS_ID_WIDTH-1:0]    win_c;
    int unsigned               idx_c;

    // Unpack the flat per-station buses
    always_comb begin
        for (int unsigned i = 0; i < NUM_RS; i++) begin
            res_a[i] = result_i[i*DATA_WIDTH +: DATA_WIDTH];
            rd_a[i]  = rd_i[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        end
    end

    // Round-robin search starting just after the last winner; a station
    // granted last cycle is masked because its ready is still high
    always_comb begin
        eligible_c = ready_i & ~inflight_q;
        grant_c    = 1'b0;
        win_c      = '0;
        idx_c      = 0;
        for (int unsigned k = 0; k < NUM_RS; k++) begin
            idx_c = (32'(last_q) + 32'd1 + k) % NUM_RS;
            if (!grant_c && eligible_c[RS_ID_WIDTH'(idx_c)]) begin
                grant_c = 1'b1;
                win_c   = RS_ID_WIDTH'(idx_c);
            end
        end
    end

    // Next-state; data/address/id hold when nothing is granted
    always_comb begin
        retire_d     = '0;
        bcast_en_d   = 1'b0;
        bcast_data_d = bcast_data_q;
        bcast_rs_d   = bcast_rs_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        last_d       = last_q;
        inflight_d   = '0;
        if (grant_c) begin
            retire_d     = NUM_RS'(1) << win_c;
            bcast_en_d   = 1'b1;
            bcast_data_d = res_a[win_c];
            bcast_rs_d   = win_c;
            rf_we_d      = writes_rd_i[win_c] && (rd_a[win_c] != '0);
            rf_waddr_d   = rd_a[win_c];
            rf_wdata_d   = res_a[win_c];
            last_d       = win_c;
            inflight_d   = NUM_RS'(1) << win_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_q     <= '0;
            bcast_en_q   <= 1'b0;
            bcast_data_q <= '0;
            bcast_rs_q   <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            last_q       <= RS_ID_WIDTH'(LAST_RESET);
            inflight_q   <= '0;
        end else begin
            retire_q     <= retire_d;
            bcast_en_q   <= bcast_en_d;
            bcast_data_q <= bcast_data_d;
            bcast_rs_q   <= bcast_rs_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            last_q       <= last_d;
            inflight_q   <= inflight_d;
        end
    end

    assign retire_o     = retire_q;
    assign bcast_en_o   = bcast_en_q;
    assign bcast_data_o = bcast_data_q;
    assign bcast_rs_o   = bcast_rs_q;
    assign rf_we_o      = rf_we_q;
    assign rf_waddr_o   = rf_waddr_q;
    assign rf_wdata_o   = rf_wdata_q;

endmodule
